xif_issue_arbiter: RTL and testbench

- Shares one CORE-V-XIF issue port and one result port of a coprocessor between NUM_REQ requesters (harts).
- Requester k always drives hartid k.
- Sits between the per-hart offload stages and the single coprocessor slave.
- Provides round-robin grant with grant lock, per-requester outstanding-instruction credit, and result demultiplexing by hartid.

---
 rtl/xif_issue_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_xif_issue_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_issue_arbiter.sv
// xif_issue_arbiter: shares one CORE-V-XIF issue port and one result port
// between NUM_REQ harts. Requester k is presented to the coprocessor as hartid k.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/ready_o     per-requester issue handshake
//   req_instr_i, req_id_i   per-requester payload (flattened, requester 0 in LSBs)
//   req_accept_o            broadcast issue_accept_i (qualify with req_ready_o)
//   req_writeback_o         broadcast issue_writeback_i
//   issue_*                 single issue port to the coprocessor
//   result_*                single result port from the coprocessor
//   res_valid_o/ready_i     per-requester result handshake
//   res_id_o, res_data_o    broadcast result payload
//   credit_full_o           requester has MAX_OUTSTANDING unretired instructions
module xif_issue_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned X_ID_WIDTH      = 4,
  parameter int unsigned X_HARTID_WIDTH  = 3,
  parameter int unsigned X_RFW_WIDTH     = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*32-1:0]         req_instr_i,
  input  logic [NUM_REQ*X_ID_WIDTH-1:0] req_id_i,
  output logic                          req_accept_o,
  output logic                          req_writeback_o,
  output logic                          issue_valid_o,
  input  logic                          issue_ready_i,
  output logic [31:0]                   issue_instr_o,
  output logic [X_HARTID_WIDTH-1:0]     issue_hartid_o,
  output logic [X_ID_WIDTH-1:0]         issue_id_o,
  input  logic                          issue_accept_i,
  input  logic                          issue_writeback_i,
  input  logic                          result_valid_i,
  output logic                          result_ready_o,
  input  logic [X_HARTID_WIDTH-1:0]     result_hartid_i,
  input  logic [X_ID_WIDTH-1:0]         result_id_i,
  input  logic [X_RFW_WIDTH-1:0]        result_data_i,
  output logic [NUM_REQ-1:0]            res_valid_o,
  input  logic [NUM_REQ-1:0]            res_ready_i,
  output logic [X_ID_WIDTH-1:0]         res_id_o,
  output logic [X_RFW_WIDTH-1:0]        res_data_o,
  output logic [NUM_REQ-1:0]            credit_full_o
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

  state_e                r_state, w_state_nxt;
  logic [PTR_W-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [PTR_W-1:0]      r_grant, w_grant_nxt;
  logic [PTR_W-1:0]      w_grant, w_rr_grant;
  logic                  w_grant_vld, w_rr_vld;
  logic [NUM_REQ-1:0]    w_elig, w_inc, w_dec, w_hit;
  logic                  w_issue_hs, w_res_hs, w_res_in_range, w_res_rdy;
  logic [INSTR_W-1:0]    w_instr [NUM_REQ];
  logic [X_ID_WIDTH-1:0] w_id    [NUM_REQ];

  // Per-requester payload unpack, eligibility, result decode and credit counter.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
    logic [CNT_W-1:0] r_cnt;

    assign w_instr[k]       = req_instr_i[k*INSTR_W +: INSTR_W];
    assign w_id[k]          = req_id_i[k*X_ID_WIDTH +: X_ID_WIDTH];
    assign w_elig[k]        = req_valid_i[k] && (r_cnt < CNT_MAX);
    assign w_inc[k]         = w_issue_hs && issue_accept_i && (w_grant == PTR_W'(k));
    assign w_hit[k]         = (result_hartid_i == X_HARTID_WIDTH'(k));
    assign w_dec[k]         = w_res_hs && w_hit[k];
    assign res_valid_o[k]   = !rst_i && result_valid_i && w_hit[k];
    assign credit_full_o[k] = !rst_i && (r_cnt == CNT_MAX);

    // Simultaneous issue and retire cancel; out-of-range moves saturate.
    always_ff @(posedge clk_i) begin : p_cnt
      if (rst_i) begin
        r_cnt <= '0;
      end else if (w_inc[k] && !w_dec[k] && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_dec[k] && !w_inc[k] && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i) begin : p_cnt_chk
      if (!rst_i) begin
        assert (!(w_inc[k] && !w_dec[k] && (r_cnt == CNT_MAX)));
        assert (!(w_dec[k] && !w_inc[k] && (r_cnt == '0)));
      end
    end
  end

  // Round-robin search: first eligible index at or after r_rr_ptr, wrapping.
  always_comb begin : p_search
    int unsigned idx;
    idx        = 0;
    w_rr_grant = '0;
    w_rr_vld   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(r_rr_ptr) + i) % NUM_REQ;
      if (!w_rr_vld && w_elig[PTR_W'(idx)]) begin
        w_rr_grant = PTR_W'(idx);
        w_rr_vld   = 1'b1;
      end
    end
  end

  // Grant FSM: a presented but unacknowledged grant is frozen until handshake.
  always_comb begin : p_fsm
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    w_grant      = w_rr_grant;
    w_grant_vld  = w_rr_vld;
    case (r_state)
      ST_IDLE: begin
        if (w_rr_vld && !issue_ready_i) begin
          w_state_nxt = ST_LOCKED;
          w_grant_nxt = w_rr_grant;
        end
      end
      ST_LOCKED: begin
        w_grant     = r_grant;
        w_grant_vld = 1'b1;
        if (issue_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
    if (w_grant_vld && issue_ready_i) begin
      w_rr_ptr_nxt = PTR_W'((32'(w_grant) + 32'd1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk_i) begin : p_state
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Issue side.
  assign issue_valid_o   = !rst_i && w_grant_vld;
  assign w_issue_hs      = issue_valid_o && issue_ready_i;
  assign issue_instr_o   = w_instr[w_grant];
  assign issue_id_o      = w_id[w_grant];
  assign issue_hartid_o  = X_HARTID_WIDTH'(w_grant);
  assign req_accept_o    = issue_accept_i;
  assign req_writeback_o = issue_writeback_i;

  always_comb begin : p_req_ready
    req_ready_o = '0;
    if (issue_valid_o) begin
      req_ready_o[w_grant] = issue_ready_i;
    end
  end

  // Result side: results for a non-existent hart are sunk so the port never stalls.
  assign w_res_in_range = |w_hit;
  assign w_res_rdy      = w_res_in_range ? |(w_hit & res_ready_i) : 1'b1;
  assign result_ready_o = !rst_i && w_res_rdy;
  assign w_res_hs       = result_valid_i && result_ready_o && w_res_in_range;
  assign res_id_o       = result_id_i;
  assign res_data_o     = result_data_i;

  always_ff @(posedge clk_i) begin : p_res_chk
    if (!rst_i) begin
      assert (!(result_valid_i && !w_res_in_range));
    end
  end

endmodule

// File: tb/tb_xif_issue_arbiter.sv
// Bench for xif_issue_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_xif_issue_arbiter;

  localparam int unsigned N    = 2;
  localparam int unsigned IDW  = 4;
  localparam int unsigned HW   = 3;
  localparam int unsigned RW   = 32;
  localparam int          MAXO = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*32-1:0]  req_instr;
  logic [N*IDW-1:0] req_id;
  logic             req_accept, req_writeback;
  logic             issue_valid, issue_ready;
  logic [31:0]      issue_instr;
  logic [HW-1:0]    issue_hartid;
  logic [IDW-1:0]   issue_id;
  logic             issue_accept, issue_writeback;
  logic             result_valid, result_ready;
  logic [HW-1:0]    result_hartid;
  logic [IDW-1:0]   result_id;
  logic [RW-1:0]    result_data;
  logic [N-1:0]     res_valid, res_ready, credit_full;
  logic [IDW-1:0]   res_id;
  logic [RW-1:0]    res_data;

  always #5 clk = ~clk;

  xif_issue_arbiter #(
    .NUM_REQ(N), .X_ID_WIDTH(IDW), .X_HARTID_WIDTH(HW),
    .X_RFW_WIDTH(RW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_instr_i(req_instr), .req_id_i(req_id),
    .req_accept_o(req_accept), .req_writeback_o(req_writeback),
    .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
    .issue_instr_o(issue_instr), .issue_hartid_o(issue_hartid), .issue_id_o(issue_id),
    .issue_accept_i(issue_accept), .issue_writeback_i(issue_writeback),
    .result_valid_i(result_valid), .result_ready_o(result_ready),
    .result_hartid_i(result_hartid), .result_id_i(result_id), .result_data_i(result_data),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_id_o(res_id), .res_data_o(res_data),
    .credit_full_o(credit_full)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: outstanding count per hart, pointer, frozen grant, last handshake.
  int m_cnt [8];
  int m_ptr    = 0;
  bit m_locked = 1'b0;
  int m_lock_k = 0;
  int m_hs_k   = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit bitk(input logic [7:0] v, input int k);
    return v[k[2:0]];
  endfunction

  function automatic int exp_grant();
    int k;
    if (rst) return -1;
    if (m_locked) return m_lock_k;
    for (int i = 0; i < N; i++) begin
      k = (m_ptr + i) % N;
      if (bitk(8'(req_valid), k) && m_cnt[k[2:0]] < MAXO) return k;
    end
    return -1;
  endfunction

  function automatic bit exp_res_ready();
    int h;
    h = int'(result_hartid);
    if (rst) return 1'b0;
    if (h >= N) return 1'b1;
    return bitk(8'(res_ready), h);
  endfunction

  task automatic model_step();
    int g;
    int h;
    bit rr;
    m_hs_k = -1;
    if (rst) begin
      for (int k = 0; k < 8; k++) m_cnt[k] = 0;
      m_ptr    = 0;
      m_locked = 1'b0;
    end else begin
      g  = exp_grant();
      h  = int'(result_hartid);
      rr = exp_res_ready();
      if (g >= 0) begin
        if (issue_ready) begin
          m_hs_k = g;
          if (issue_accept) m_cnt[g[2:0]] += 1;
          m_ptr    = (g + 1) % N;
          m_locked = 1'b0;
        end else begin
          m_locked = 1'b1;
          m_lock_k = g;
        end
      end
      if (result_valid && h < N && rr) m_cnt[h[2:0]] -= 1;
    end
  endtask

  task automatic compare_all();
    int g;
    int h;
    logic [N-1:0] e_rdy, e_rv, e_full;
    g = exp_grant();
    h = int'(result_hartid);
    e_rdy  = (g >= 0 && issue_ready) ? (N'(1) << g) : '0;
    e_rv   = (!rst && result_valid && h < N) ? (N'(1) << h) : '0;
    e_full = '0;
    for (int k = 0; k < N; k++)
      if (!rst && m_cnt[k[2:0]] == MAXO) e_full |= N'(1) << k;
    chk("issue_valid", 64'(issue_valid), 64'(g >= 0));
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    if (g >= 0) begin
      chk("issue_hartid", 64'(issue_hartid), 64'(g));
      chk("issue_instr", 64'(issue_instr), 64'(32'(req_instr >> (32 * g))));
      chk("issue_id", 64'(issue_id), 64'(IDW'(req_id >> (IDW * g))));
    end
    chk("res_valid", 64'(res_valid), 64'(e_rv));
    chk("result_ready", 64'(result_ready), 64'(exp_res_ready()));
    chk("credit_full", 64'(credit_full), 64'(e_full));
    chk("req_accept", 64'(req_accept), 64'(issue_accept));
    chk("req_writeback", 64'(req_writeback), 64'(issue_writeback));
    chk("res_id", 64'(res_id), 64'(result_id));
    chk("res_data", 64'(res_data), 64'(result_data));
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) compare_all();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    req_valid = '0; issue_ready = 1'b0; issue_accept = 1'b0; issue_writeback = 1'b0;
    result_valid = 1'b0; result_hartid = '0; res_ready = '0;
  endtask

  // Return every outstanding instruction, one result per cycle.
  task automatic drain();
    for (int c = 0; c < 40; c++) begin
      req_valid = '0; res_ready = '1; result_valid = 1'b0;
      for (int k = N - 1; k >= 0; k--)
        if (m_cnt[k[2:0]] > 0) begin result_valid = 1'b1; result_hartid = HW'(k); end
      if (!result_valid) break;
      tick();
    end
    result_valid = 1'b0;
  endtask

  initial begin
    logic [N-1:0] pend;
    int k0;
    rst = 1'b1;
    set_idle();
    req_instr = '0; req_id = '0; result_id = '0; result_data = '0;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_credit_full", 64'(credit_full), 64'd0);
    chk("rst_result_ready", 64'(result_ready), 64'd0);
    tick();
    rst = 1'b0;

    // Fairness: both requesting, immediate results.
    req_valid = 2'b11; req_instr = {32'hBBBB_0001, 32'hAAAA_0000}; req_id = {4'h1, 4'h0};
    issue_ready = 1'b1; issue_accept = 1'b1; res_ready = 2'b11;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) req_valid = 2'b01;
      @(negedge clk);
      chk("fair_hartid", 64'(issue_hartid), 64'(i % 2));
      tick();
      result_valid = (m_hs_k >= 0);
      if (m_hs_k >= 0) result_hartid = HW'(m_hs_k);
    end
    drain();

    // Backpressure lock.
    issue_accept = 1'b0; issue_ready = 1'b0; req_valid = 2'b01;
    req_instr = {32'h2222_0002, 32'h1111_0001};
    for (int i = 0; i < 3; i++) begin
      if (i == 1) req_valid = 2'b11;
      @(negedge clk);
      chk("lock_hartid", 64'(issue_hartid), 64'd0);
      chk("lock_instr", 64'(issue_instr), 64'h1111_0001);
      tick();
    end
    issue_ready = 1'b1;
    @(negedge clk); chk("lock_hs_ready", 64'(req_ready), 64'h1); tick();
    @(negedge clk); chk("lock_next_hartid", 64'(issue_hartid), 64'd1); tick();
    req_valid = 2'b01;
    @(negedge clk); chk("lock_back_hartid", 64'(issue_hartid), 64'd0); tick();
    req_valid = '0;

    // Credit exhaustion.
    issue_accept = 1'b1;
    req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("cred_hartid", 64'(issue_hartid), 64'd0); tick();
    end
    req_valid = 2'b11;
    @(negedge clk);
    chk("cred_full", 64'(credit_full), 64'h1);
    chk("cred_skip", 64'(issue_hartid), 64'd1);
    tick();
    req_valid = 2'b01; result_valid = 1'b1; result_hartid = 3'd0; res_ready = 2'b11;
    @(negedge clk);
    chk("cred_blocked", 64'(issue_valid), 64'd0);
    chk("cred_rel_ready", 64'(result_ready), 64'd1);
    tick();
    result_valid = 1'b0; issue_accept = 1'b0;
    @(negedge clk);
    chk("cred_regrant_v", 64'(issue_valid), 64'd1);
    chk("cred_regrant_h", 64'(issue_hartid), 64'd0);
    chk("cred_notfull", 64'(credit_full), 64'd0);
    tick();
    drain();

    // Rejected instructions consume no credit.
    issue_accept = 1'b0; issue_ready = 1'b1; req_valid = 2'b01;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rej_full", 64'(credit_full), 64'd0);
      chk("rej_accept", 64'(req_accept), 64'd0);
      tick();
    end
    req_valid = '0;
    @(negedge clk); chk("rej_full_end", 64'(credit_full), 64'd0); tick();

    // Simultaneous issue and retire on hart 1.
    issue_accept = 1'b1; req_valid = 2'b10; res_ready = 2'b11;
    repeat (3) tick();
    result_valid = 1'b1; result_hartid = 3'd1;
    tick();
    result_valid = 1'b0;
    @(negedge clk); chk("sim_still_elig", 64'(issue_valid), 64'd1); tick();
    req_valid = '0;
    @(negedge clk); chk("sim_full", 64'(credit_full), 64'h2); tick();

    // Result routing, then reset while locked.
    result_valid = 1'b1; result_hartid = 3'd1; res_ready = 2'b01;
    @(negedge clk);
    chk("route_valid", 64'(res_valid), 64'h2);
    chk("route_ready", 64'(result_ready), 64'd0);
    tick();
    result_valid = 1'b0; issue_ready = 1'b0; issue_accept = 1'b0; req_valid = 2'b01;
    @(negedge clk); chk("rl_locked_v", 64'(issue_valid), 64'd1); tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rl_rst_valid", 64'(issue_valid), 64'd0);
    chk("rl_rst_ready", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0; req_valid = 2'b10; issue_ready = 1'b1;
    @(negedge clk);
    chk("rl_cnt_clr", 64'(credit_full), 64'd0);
    chk("rl_unlock_v", 64'(issue_valid), 64'd1);
    chk("rl_unlock_h", 64'(issue_hartid), 64'd1);
    tick();
    req_valid = '0;
    tick();

    // Randomized traffic; requesters hold valid/payload until acknowledged.
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      if (rst) pend = '0;
      else if (m_hs_k >= 0) pend &= ~(N'(1) << m_hs_k);
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < N; k++) begin
        if (!bitk(8'(pend), k) && $urandom_range(0, 2) != 0) begin
          pend |= N'(1) << k;
          req_instr[32*k +: 32] = $urandom;
          req_id[IDW*k +: IDW]  = IDW'($urandom);
        end
      end
      req_valid       = pend;
      issue_ready     = ($urandom_range(0, 3) != 0);
      issue_accept    = ($urandom_range(0, 3) != 0);
      issue_writeback = 1'($urandom);
      res_ready       = N'($urandom);
      result_id       = IDW'($urandom);
      result_data     = $urandom;
      k0 = int'($urandom_range(0, N - 1));
      if (m_cnt[k0[2:0]] > 0 && $urandom_range(0, 1) != 0) begin
        result_valid  = 1'b1;
        result_hartid = HW'(k0);
      end else begin
        result_valid  = 1'b0;
        result_hartid = HW'($urandom_range(0, 7));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
